// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: handshake bus for the execute-stage ALU.
//   master : upstream decoder + result consumer (drives op/operands, result_ready_i)
//   slave  : alu_exec_unit (drives start_ready_o and the registered result)
// Signals:
//   start_valid_i / start_ready_o    : op acceptance handshake
//   alu_control_op_i                 : 4-bit ALU control code
//   operand_a_i / operand_b_i        : rs1 and rs2/immediate
//   result_valid_o / result_ready_i  : result handshake
//   result_o, zero_o, illegal_o      : result payload
interface alu_exec_unit_if #(
   parameter int XLEN = 32
);
   logic            start_valid_i;
   logic            start_ready_o;
   logic [3:0]      alu_control_op_i;
   logic [XLEN-1:0] operand_a_i;
   logic [XLEN-1:0] operand_b_i;
   logic            result_valid_o;
   logic            result_ready_i;
   logic [XLEN-1:0] result_o;
   logic            zero_o;
   logic            illegal_o;

   modport master (
      output start_valid_i, alu_control_op_i, operand_a_i, operand_b_i, result_ready_i,
      input  start_ready_o, result_valid_o, result_o, zero_o, illegal_o
   );

   modport slave (
      input  start_valid_i, alu_control_op_i, operand_a_i, operand_b_i, result_ready_i,
      output start_ready_o, result_valid_o, result_o, zero_o, illegal_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU behind the ALU control decoder.
//   Logic/arith/compare ops finish in one cycle; shifts use a serial
//   one-bit-per-cycle shifter (latency 1 + shamt).
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset, aborts any op in flight
//   bus   : alu_exec_unit_if.slave (op/operand and result handshakes)
// Optional feature: define ALU_EXEC_SLTU_EN to decode op 1001 as sltu;
//   otherwise 1001 is reported as illegal.
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   alu_exec_unit_if.slave bus
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
`ifdef ALU_EXEC_SLTU_EN
   localparam logic [3:0] OP_SLTU = 4'b1001;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

   state_t              state_q, state_d;
   shift_kind_t         kind_q, kind_d;
   logic [XLEN-1:0]     acc_q, acc_d;     // shift accumulator, doubles as result register
   logic [SHAMT_W-1:0]  cnt_q, cnt_d;
   logic                zero_q, zero_d;
   logic                ill_q, ill_d;

   logic [XLEN-1:0]     a, b, alu_res, shift_one;
   logic [SHAMT_W-1:0]  shamt;

   assign a     = bus.operand_a_i;
   assign b     = bus.operand_b_i;
   assign shamt = b[SHAMT_W-1:0];

   // single-bit step of the serial shifter
   always_comb begin
      shift_one = acc_q;
      case (kind_q)
         SK_SLL:  shift_one = {acc_q[XLEN-2:0], 1'b0};
         SK_SRL:  shift_one = {1'b0, acc_q[XLEN-1:1]};
         SK_SRA:  shift_one = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
         default: shift_one = acc_q;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (bus.alu_control_op_i)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD:  alu_res = a + b;
         OP_XOR:  alu_res = a ^ b;
         OP_SUB:  alu_res = a - b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef ALU_EXEC_SLTU_EN
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
`endif
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      ill_d   = ill_q;
      case (state_q)
         IDLE: begin
            if (bus.start_valid_i) begin
               case (bus.alu_control_op_i)
                  OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT
`ifdef ALU_EXEC_SLTU_EN
                  , OP_SLTU
`endif
                  : begin
                     acc_d   = alu_res;
                     zero_d  = (alu_res == '0);
                     ill_d   = 1'b0;
                     state_d = DONE;
                  end
                  OP_SLL, OP_SRL, OP_SRA: begin
                     acc_d  = a;
                     cnt_d  = shamt;
                     ill_d  = 1'b0;
                     kind_d = (bus.alu_control_op_i == OP_SLL) ? SK_SLL :
                              (bus.alu_control_op_i == OP_SRL) ? SK_SRL : SK_SRA;
                     if (shamt == '0) begin
                        zero_d  = (a == '0);
                        state_d = DONE;
                     end else begin
                        state_d = SHIFT;
                     end
                  end
                  default: begin
                     acc_d   = '0;
                     zero_d  = 1'b1;
                     ill_d   = 1'b1;
                     state_d = DONE;
                  end
               endcase
            end
         end
         SHIFT: begin
            acc_d = shift_one;
            cnt_d = cnt_q - SHAMT_W'(1);
            // zero flag only matters once the final step lands
            if (cnt_q == SHAMT_W'(1)) begin
               zero_d  = (shift_one == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.result_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         kind_q  <= SK_SLL;
         acc_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
      end
   end

   assign bus.start_ready_o  = (state_q == IDLE);
   assign bus.result_valid_o = (state_q == DONE);
   assign bus.result_o       = acc_q;
   assign bus.zero_o         = zero_q;
   assign bus.illegal_o      = ill_q;

endmodule
